// File: rtl/fetch_resp_128.sv
`default_nettype none
// fetch_resp_128: memory-side responder for the 128-bit req/gnt/rvalid fetch protocol.
// Returns address-derived lines in grant order after LATENCY cycles; grant stalls come from an LFSR.
module fetch_resp_128 #(
  parameter int          FETCH_ADDR_WIDTH = 32,
  parameter int          FETCH_DATA_WIDTH = 128,
  parameter int          LATENCY          = 2,
  parameter int          MAX_OUTSTANDING  = 4,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_req_i,
  input  logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                        fetch_gnt_o,
  output logic                        fetch_rvalid_o,
  output logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_o,
  input  logic [3:0]                  stall_rate_i,
  input  logic                        rsp_hold_i,
  output logic [31:0]                 n_granted_o,
  output logic [31:0]                 n_resp_o,
  output logic                        err_misaligned_o
);

  localparam int              PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int              CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_OUTSTANDING);
  localparam logic [4:0]      LAT5  = 5'(LATENCY);

  logic [15:0]                 lfsr;
  logic                        stall;
  logic                        push;
  logic                        pop;
  logic                        head_eligible;
  logic [PTR_W-1:0]            head;
  logic [PTR_W-1:0]            tail;
  logic [CNT_W-1:0]            count;
  logic [FETCH_ADDR_WIDTH-1:0] addr_q [MAX_OUTSTANDING];
  logic [3:0]                  age_q  [MAX_OUTSTANDING];
  logic [31:0]                 base;
  logic [FETCH_DATA_WIDTH-1:0] line;

  assign stall       = lfsr[3:0] < stall_rate_i;
  // Registered occupancy only: a same-cycle pop never frees a slot for this cycle's grant.
  assign fetch_gnt_o = fetch_req_i & ~stall & (count < DEPTH);
  assign push        = fetch_req_i & fetch_gnt_o;

  // age+1 >= LATENCY is age >= LATENCY-1 without a constant compare when LATENCY is 1.
  assign head_eligible = (count != '0) && (({1'b0, age_q[head]} + 5'd1) >= LAT5);
  assign pop           = head_eligible & ~rsp_hold_i;

  assign base = 32'(addr_q[head]) & 32'hFFFF_FFF0;

  for (genvar k = 0; k < FETCH_DATA_WIDTH / 32; k++) begin : g_word
    assign line[32*k +: 32] = base + 32'(4 * k);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr             <= LFSR_SEED;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      fetch_rvalid_o   <= 1'b0;
      fetch_rdata_o    <= '0;
      n_granted_o      <= '0;
      n_resp_o         <= '0;
      err_misaligned_o <= 1'b0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      fetch_rvalid_o <= pop;
      if (pop)  fetch_rdata_o <= line;
      if (push) n_granted_o   <= n_granted_o + 32'd1;
      if (pop)  n_resp_o      <= n_resp_o + 32'd1;
      if (push && (fetch_addr_i[3:0] != 4'd0)) err_misaligned_o <= 1'b1;
    end
  end

  // Slot storage needs no reset: a slot is only read after a push has written it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (age_q[i] != 4'hF) age_q[i] <= age_q[i] + 4'd1;
    end
    if (push) begin
      addr_q[tail] <= fetch_addr_i;
      age_q[tail]  <= 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_resp_128.sv
`default_nettype none
// tb_fetch_resp_128: drives a LATENCY=1 and a LATENCY=3 responder with shared stimulus
// and compares both against a transaction-log reference model.
module tb_fetch_resp_128;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          LOGN = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [3:0]  rate  = 4'd0;
  logic        hold  = 1'b0;

  logic [1:0]   gnt, rvalid, err;
  logic [127:0] rdata [2];
  logic [31:0]  ng [2];
  logic [31:0]  nr [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_resp_128 #(.FETCH_ADDR_WIDTH(32), .FETCH_DATA_WIDTH(128), .LATENCY(1),
                   .MAX_OUTSTANDING(4), .LFSR_SEED(SEED)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .fetch_req_i(req), .fetch_addr_i(addr),
    .fetch_gnt_o(gnt[0]), .fetch_rvalid_o(rvalid[0]), .fetch_rdata_o(rdata[0]),
    .stall_rate_i(rate), .rsp_hold_i(hold), .n_granted_o(ng[0]), .n_resp_o(nr[0]),
    .err_misaligned_o(err[0])
  );

  fetch_resp_128 #(.FETCH_ADDR_WIDTH(32), .FETCH_DATA_WIDTH(128), .LATENCY(3),
                   .MAX_OUTSTANDING(4), .LFSR_SEED(SEED)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .fetch_req_i(req), .fetch_addr_i(addr),
    .fetch_gnt_o(gnt[1]), .fetch_rvalid_o(rvalid[1]), .fetch_rdata_o(rdata[1]),
    .stall_rate_i(rate), .rsp_hold_i(hold), .n_granted_o(ng[1]), .n_resp_o(nr[1]),
    .err_misaligned_o(err[1])
  );

  // Reference model: a log of granted transactions stamped with their granting edge.
  logic [31:0]  log_addr [2][LOGN];
  longint       log_edge [2][LOGN];
  int           wr_idx [2] = '{0, 0};
  int           rd_idx [2] = '{0, 0};
  longint       edge_no = 0;
  logic [15:0]  m_lfsr = SEED;
  logic         exp_rvalid [2] = '{1'b0, 1'b0};
  logic [127:0] exp_rdata [2] = '{128'd0, 128'd0};
  logic [31:0]  exp_ng [2] = '{32'd0, 32'd0};
  logic [31:0]  exp_nr [2] = '{32'd0, 32'd0};
  logic         exp_err [2] = '{1'b0, 1'b0};

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int v;
    int b;
    v = int'(s);
    b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  b;
    b = a - (a % 32'd16);
    for (int k = 0; k < 4; k++) l[32*k +: 32] = b + 32'(4 * k);
    return l;
  endfunction

  function automatic bit m_grant(int d);
    return req && (int'(m_lfsr[3:0]) >= int'(rate)) && ((wr_idx[d] - rd_idx[d]) < 4);
  endfunction

  function automatic bit m_give(int d);
    return (wr_idx[d] != rd_idx[d]) && !hold &&
           ((edge_no - log_edge[d][rd_idx[d] % LOGN]) >= longint'(lat_of(d)));
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        rd_idx[d]     <= wr_idx[d];
        exp_rvalid[d] <= 1'b0;
        exp_rdata[d]  <= '0;
        exp_ng[d]     <= '0;
        exp_nr[d]     <= '0;
        exp_err[d]    <= 1'b0;
      end else begin
        exp_rvalid[d] <= m_give(d);
        if (m_give(d)) begin
          exp_rdata[d] <= line_of(log_addr[d][rd_idx[d] % LOGN]);
          rd_idx[d]    <= rd_idx[d] + 1;
          exp_nr[d]    <= exp_nr[d] + 32'd1;
        end
        if (m_grant(d)) begin
          log_addr[d][wr_idx[d] % LOGN] <= addr;
          log_edge[d][wr_idx[d] % LOGN] <= edge_no;
          wr_idx[d] <= wr_idx[d] + 1;
          exp_ng[d] <= exp_ng[d] + 32'd1;
          if (addr[3:0] != 4'd0) exp_err[d] <= 1'b1;
        end
      end
    end
    m_lfsr  <= rst_n ? lfsr_step(m_lfsr) : SEED;
    edge_no <= edge_no + 1;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0; hold = 1'b0; rate = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (rvalid[d] !== 1'b0) begin errors++; $display("FAIL reset_rvalid dut%0d: got %b want 0", d, rvalid[d]); end
      checks++; if (rdata[d] !== 128'd0) begin errors++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata[d]); end
      checks++; if (ng[d] !== 32'd0) begin errors++; $display("FAIL reset_n_granted dut%0d: got %0d want 0", d, ng[d]); end
      checks++; if (nr[d] !== 32'd0) begin errors++; $display("FAIL reset_n_resp dut%0d: got %0d want 0", d, nr[d]); end
      checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b want 0", d, err[d]); end
      checks++; if (gnt[d] !== 1'b0) begin errors++; $display("FAIL reset_gnt dut%0d: got %b want 0", d, gnt[d]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream_lat1();
    req = 1'b1; addr = 32'h100; rate = 4'd0; hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL stream_gnt cycle%0d: got %b want 1", i, gnt[0]); end
      @(negedge clk);
      checks++; if (rvalid[0] !== (i >= 1)) begin errors++; $display("FAIL stream_rvalid cycle%0d: got %b want %b", i, rvalid[0], i >= 1); end
      if (i >= 1) begin
        checks++;
        if (rdata[0] !== 128'h0000010C_00000108_00000104_00000100) begin
          errors++; $display("FAIL stream_rdata cycle%0d: got %h want 0000010c000001080000010400000100", i, rdata[0]);
        end
      end
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single_lat3();
    apply_reset();
    req = 1'b1; addr = 32'h0FF0;
    #1;
    checks++; if (gnt[1] !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b want 1", gnt[1]); end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) req = 1'b0;
      checks++; if (rvalid[1] !== (j == 3)) begin errors++; $display("FAIL single_rvalid edge%0d: got %b want %b", j, rvalid[1], j == 3); end
      if (j == 3) begin
        checks++;
        if (rdata[1] !== 128'h00000FFC_00000FF8_00000FF4_00000FF0) begin
          errors++; $display("FAIL single_rdata: got %h want 00000ffc00000ff800000ff400000ff0", rdata[1]);
        end
      end
    end
    checks++; if (ng[1] !== 32'd1) begin errors++; $display("FAIL single_n_granted: got %0d want 1", ng[1]); end
    checks++; if (nr[1] !== 32'd1) begin errors++; $display("FAIL single_n_resp: got %0d want 1", nr[1]); end
  endtask

  task automatic test_full_hold();
    apply_reset();
    hold = 1'b1; req = 1'b1; addr = 32'h1000;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (gnt[0] !== (i < 4)) begin errors++; $display("FAIL full_gnt cycle%0d: got %b want %b", i, gnt[0], i < 4); end
      @(negedge clk);
      if (i < 4) addr = addr + 32'd16;
    end
    req = 1'b0; hold = 1'b0;
    checks++; if (ng[0] !== 32'd4) begin errors++; $display("FAIL full_n_granted: got %0d want 4", ng[0]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rvalid[0] !== (i < 4)) begin errors++; $display("FAIL full_rvalid cycle%0d: got %b want %b", i, rvalid[0], i < 4); end
      if (i < 4) begin
        checks++;
        if (rdata[0][31:0] !== 32'h1000 + 32'(16 * i)) begin
          errors++; $display("FAIL full_order cycle%0d: got %h want %h", i, rdata[0][31:0], 32'h1000 + 32'(16 * i));
        end
      end
      if (i == 0) begin
        req = 1'b1;
        #1;
        checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL full_gnt_return: got %b want 1", gnt[0]); end
        req = 1'b0;
      end
    end
  endtask

  task automatic test_stall_rate();
    int seen;
    apply_reset();
    seen = 0; rate = 4'd15; req = 1'b1; addr = 32'h4000;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (gnt[0] === 1'b1) seen++;
      checks++; if (gnt[0] !== m_grant(0)) begin errors++; $display("FAIL stall15_gnt cycle%0d: got %b want %b", i, gnt[0], m_grant(0)); end
      @(negedge clk);
    end
    checks++; if (seen !== int'(exp_ng[0])) begin errors++; $display("FAIL stall15_count: got %0d want %0d", seen, exp_ng[0]); end
    checks++; if (ng[0] !== exp_ng[0]) begin errors++; $display("FAIL stall15_n_granted: got %0d want %0d", ng[0], exp_ng[0]); end
    checks++; if (seen < 20 || seen > 150) begin errors++; $display("FAIL stall15_rate: got %0d grants want 20..150", seen); end
    rate = 4'd0;
    for (int i = 0; i < 100; i++) begin
      #1;
      checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL stall0_gnt cycle%0d: got %b want 1", i, gnt[0]); end
      @(negedge clk);
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_misaligned();
    apply_reset();
    req = 1'b1; addr = 32'h104;
    #1;
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL misal_pre_err: got %b want 0", err[0]); end
    @(negedge clk);
    req = 1'b0;
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL misal_err: got %b want 1", err[0]); end
    @(negedge clk);
    checks++; if (rvalid[0] !== 1'b1) begin errors++; $display("FAIL misal_rvalid: got %b want 1", rvalid[0]); end
    checks++; if (rdata[0][63:0] !== 64'h00000104_00000100) begin errors++; $display("FAIL misal_rdata: got %h want 0000010400000100", rdata[0][63:0]); end
    repeat (5) @(negedge clk);
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL misal_sticky: got %b want 1", err[0]); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    hold = 1'b1; req = 1'b1; addr = 32'h800;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      addr = addr + 32'd16;
    end
    req = 1'b0;
    checks++; if (ng[0] !== 32'd3) begin errors++; $display("FAIL midrst_pre_n_granted: got %0d want 3", ng[0]); end
    rst_n = 1'b0; hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (rvalid[d] !== 1'b0) begin errors++; $display("FAIL midrst_rvalid dut%0d: got %b want 0", d, rvalid[d]); end
      checks++; if (ng[d] !== 32'd0) begin errors++; $display("FAIL midrst_n_granted dut%0d: got %0d want 0", d, ng[d]); end
      checks++; if (nr[d] !== 32'd0) begin errors++; $display("FAIL midrst_n_resp dut%0d: got %0d want 0", d, nr[d]); end
    end
    req = 1'b1;
    #1;
    checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL midrst_gnt: got %b want 1", gnt[0]); end
    req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL midrst_stale cycle%0d: got %b want 00", i, rvalid); end
    end
  endtask

  task automatic test_random();
    rate = 4'($urandom_range(0, 15));
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      req   = ($urandom_range(0, 9) < 7);
      addr  = $urandom;
      if ($urandom_range(0, 7) != 0) addr[3:0] = 4'd0;
      if ($urandom_range(0, 49) == 0) rate = 4'($urandom_range(0, 15));
      hold  = ($urandom_range(0, 3) == 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++; if (gnt[d] !== m_grant(d)) begin errors++; $display("FAIL rnd_gnt dut%0d cycle%0d: got %b want %b", d, i, gnt[d], m_grant(d)); end
        checks++; if (rvalid[d] !== exp_rvalid[d]) begin errors++; $display("FAIL rnd_rvalid dut%0d cycle%0d: got %b want %b", d, i, rvalid[d], exp_rvalid[d]); end
        checks++; if (rdata[d] !== exp_rdata[d]) begin errors++; $display("FAIL rnd_rdata dut%0d cycle%0d: got %h want %h", d, i, rdata[d], exp_rdata[d]); end
        checks++; if (ng[d] !== exp_ng[d]) begin errors++; $display("FAIL rnd_n_granted dut%0d cycle%0d: got %0d want %0d", d, i, ng[d], exp_ng[d]); end
        checks++; if (nr[d] !== exp_nr[d]) begin errors++; $display("FAIL rnd_n_resp dut%0d cycle%0d: got %0d want %0d", d, i, nr[d], exp_nr[d]); end
        checks++; if (err[d] !== exp_err[d]) begin errors++; $display("FAIL rnd_err dut%0d cycle%0d: got %b want %b", d, i, err[d], exp_err[d]); end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream_lat1();
    test_single_lat3();
    test_full_hold();
    test_stall_rate();
    test_misaligned();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_resp_128.md
Name: fetch_resp_128

Overview:
- Responder (memory-side model) for the 128-bit instruction-fetch req/gnt/rvalid protocol.
- Accepts fetch requests from an initiator (traffic generator or icache fetch port) and returns deterministic, address-derived 128-bit lines, in order, after a programmable latency.
- Grant back-pressure is pseudo-random and rate-controlled; response back-pressure is controlled by input.
- Used as the slave end in cache/TB regressions; provides self-checkable data and transaction counters.

Parameters:
- FETCH_ADDR_WIDTH, 32, fetch address width.
- FETCH_DATA_WIDTH, 128, line width; fixed at 128, four 32-bit words.
- LATENCY, 2, minimum cycles from granting edge to rvalid; legal range 1..15.
- MAX_OUTSTANDING, 4, request queue depth; power of two, 2..16.
- LFSR_SEED, 16'hACE1, grant-stall LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- fetch_req_i  in  1  request valid.
- fetch_addr_i  in  FETCH_ADDR_WIDTH  request address.
- fetch_gnt_o  out  1  grant, combinational.
- fetch_rvalid_o  out  1  response valid, registered.
- fetch_rdata_o  out  FETCH_DATA_WIDTH  response line, registered.
- stall_rate_i  in  4  grant-stall rate, 0 = never stall.
- rsp_hold_i  in  1  suppresses response delivery while high.
- n_granted_o  out  32  granted-transaction count.
- n_resp_o  out  32  delivered-response count.
- err_misaligned_o  out  1  sticky; set when any address with addr[3:0] != 0 is granted.

Behaviour:
- Reset: synchronous on rst_n == 0 at a clk edge. rvalid, rdata, both counters and err clear to 0. Queue is flushed and in-flight responses are discarded. LFSR loads LFSR_SEED.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, advances every cycle when not in reset.
- Stall signal: stall = (lfsr[3:0] < stall_rate_i).
- Grant: fetch_gnt_o = fetch_req_i & ~stall & (occupancy < MAX_OUTSTANDING).
  - Occupancy is the registered value; a pop in the same cycle does not free a slot for that cycle's grant.
- Handshake: a transfer occurs at an edge where req & gnt. The initiator may change or drop req at any time before grant; the responder imposes no stability rule.
- Push: on transfer, push {addr, age=0} into the in-order queue. Every queued entry's age increments each cycle, saturating at 15.
- Eligibility: the head entry is eligible when age >= LATENCY-1.
- Delivery: at an edge where the head is eligible and rsp_hold_i == 0, pop the head and register rvalid=1 plus its rdata. Otherwise rvalid=0 next cycle.
  - Result: the earliest rvalid is high during the cycle beginning LATENCY edges after the granting edge.
  - LATENCY=1: rvalid is high the cycle immediately after grant.
- Throughput: at most one response per cycle. Responses are strictly in grant order.
- rdata: word k (bits 32k+31:32k) = {addr[31:4], 4'b0} + 4*k, for k = 0..3. The misaligned low nibble is ignored for data.
- rdata hold: rdata holds its last value when rvalid=0.
- Simultaneous push and pop in one cycle: occupancy is unchanged and both actions complete.
- Full queue: gnt=0 regardless of req. No request is dropped.
- Empty queue with rsp_hold_i high: no effect.
- Counters: n_granted_o increments on each transfer; n_resp_o increments on each rvalid cycle. Both wrap modulo 2^32.
- Invariant: n_granted_o - n_resp_o equals occupancy plus pending, and is <= MAX_OUTSTANDING.
- Mid-operation reset: outstanding requests are lost. The initiator must also be reset.

Test Plan:
- LATENCY=1, stall_rate_i=0, continuous req at addr 0x100 → gnt every cycle; rvalid the next cycle; rdata = 0x0000010C_00000108_00000104_00000100.
- LATENCY=3, single request at addr 0x0FF0 → rvalid exactly 3 cycles after granting edge; one-cycle pulse; n_granted_o = n_resp_o = 1.
- MAX_OUTSTANDING=4, rsp_hold_i=1, req held high → exactly 4 grants, then gnt=0. Release hold → 4 in-order rvalids on consecutive cycles; gnt returns the cycle after occupancy < 4.
- stall_rate_i=15 for 1000 cycles with req high → gnt count matches a reference LFSR model (~15/16 stalled). stall_rate_i=0 → no stalls.
- Request at addr 0x104 → err_misaligned_o rises after the grant and stays 1; rdata word0 = 0x100.
- Assert rst_n=0 for one cycle with 3 requests outstanding → next cycle rvalid=0, counters=0, gnt available; no stale rvalid afterwards.
